// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad matrix scanner.
//   ROWS / COLS  - matrix dimensions
//   CODE_W       - width of the reported key code {row_idx, col_idx}
//   state_e      - scanner FSM states
//   first_low_row- priority encoder picking the lowest-numbered low row line
package keypad_pkg;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_e;

    // Row 0 has the highest priority, so scan downwards and let the lowest
    // low bit overwrite any earlier hit.
    function automatic logic [1:0] first_low_row(input logic [ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// keypad_matrix_scanner_if: keypad pin and key-report bundle.
//   key_row     - row sense lines, active-low (board -> scanner)
//   key_col     - column drive, active-low one-hot (scanner -> board)
//   key_code    - last accepted key {row_idx, col_idx}
//   key_valid   - one-cycle strobe on an accepted press
//   key_pressed - high while the accepted key is held
// master: the scanner; slave: the board/consumer side.
interface keypad_matrix_scanner_if;
    import keypad_pkg::*;

    logic [ROWS-1:0]   key_row;
    logic [COLS-1:0]   key_col;
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_pressed;

    modport master (
        input  key_row,
        output key_col,
        output key_code,
        output key_valid,
        output key_pressed
    );

    modport slave (
        output key_row,
        input  key_col,
        input  key_code,
        input  key_valid,
        input  key_pressed
    );
endinterface

// File: rtl/keypad_scan_tick.sv
// keypad_scan_tick: scan-rate prescaler.
//   clk   - system clock
//   reset - asynchronous active-low reset
//   tick  - one-cycle pulse every SCAN_DIV clocks (while the count is SCAN_DIV-1)
module keypad_scan_tick #(
    parameter int SCAN_DIV = 2500
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick_q, tick_d;

    // Next prescaler count; tick is registered so it lines up with pre_q == LAST.
    always_comb begin
        if (pre_q == LAST) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + PW'(1);
        end
        tick_d = (pre_d == LAST);
    end

    // Prescaler and tick registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: scans a 4x4 push-button matrix one column at a time,
// debounces the first key found and reports it.
//   clk   - system clock
//   reset - asynchronous active-low reset
//   kp    - keypad bundle (master): key_row in; key_col, key_code,
//           key_valid, key_pressed out
// Parameters: SCAN_DIV clocks per scan tick (>= 4), DEBOUNCE_SCANS agreeing
// ticks to accept a press or a release (>= 1).
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 2500,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    keypad_matrix_scanner_if.master kp
);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic tick;

    logic [ROWS-1:0]   sync1_q, sync1_d;
    logic [ROWS-1:0]   sync2_q, sync2_d;
    state_e            state_q, state_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [1:0]        cand_row_q, cand_row_d;
    logic [1:0]        cand_col_q, cand_col_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  rel_cnt_q, rel_cnt_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_pressed_q, key_pressed_d;
    logic [COLS-1:0]   key_col_q, key_col_d;

    logic [ROWS-1:0]   rs;
    logic              cand_bit;

    keypad_scan_tick #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign rs       = sync2_q;
    assign cand_bit = rs[cand_row_q];

    // Scanner next-state: synchronizer shift, FSM and key reporting.
    always_comb begin
        sync1_d       = kp.key_row;
        sync2_d       = sync1_q;
        state_d       = state_q;
        col_idx_d     = col_idx_q;
        cand_row_d    = cand_row_q;
        cand_col_d    = cand_col_q;
        cnt_d         = cnt_q;
        rel_cnt_d     = rel_cnt_q;
        key_code_d    = key_code_q;
        key_pressed_d = key_pressed_q;
        key_valid_d   = 1'b0;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (rs == 4'hF) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        cand_row_d = first_low_row(rs);
                        cand_col_d = col_idx_q;
                        cnt_d      = CNT_ONE;
                        if (DEBOUNCE_SCANS == 1) begin
                            key_code_d    = {first_low_row(rs), col_idx_q};
                            key_pressed_d = 1'b1;
                            key_valid_d   = 1'b1;
                            cnt_d         = '0;
                            state_d       = HELD;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!cand_bit) begin
                        // cnt never exceeds DEBOUNCE_SCANS-1 here, so +1 cannot overflow.
                        if ((cnt_q + CNT_ONE) >= CNT_MAX) begin
                            key_code_d    = {cand_row_q, cand_col_q};
                            key_pressed_d = 1'b1;
                            key_valid_d   = 1'b1;
                            cnt_d         = '0;
                            state_d       = HELD;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        cnt_d     = '0;
                        col_idx_d = col_idx_q + 2'd1;
                        state_d   = SCAN;
                    end
                end
                HELD: begin
                    if (cand_bit) begin
                        if ((rel_cnt_q + CNT_ONE) >= CNT_MAX) begin
                            key_pressed_d = 1'b0;
                            rel_cnt_d     = '0;
                            col_idx_d     = col_idx_q + 2'd1;
                            state_d       = SCAN;
                        end else begin
                            rel_cnt_d = rel_cnt_q + CNT_ONE;
                        end
                    end else begin
                        rel_cnt_d = '0;
                    end
                end
                default: begin
                    state_d   = SCAN;
                    cnt_d     = '0;
                    rel_cnt_d = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        key_col_d = ~(4'b0001 << col_idx_d);
    end

    // Scanner state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q       <= 4'hF;
            sync2_q       <= 4'hF;
            state_q       <= SCAN;
            col_idx_q     <= 2'd0;
            cand_row_q    <= 2'd0;
            cand_col_q    <= 2'd0;
            cnt_q         <= '0;
            rel_cnt_q     <= '0;
            key_code_q    <= 4'h0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
            key_col_q     <= 4'b1110;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            state_q       <= state_d;
            col_idx_q     <= col_idx_d;
            cand_row_q    <= cand_row_d;
            cand_col_q    <= cand_col_d;
            cnt_q         <= cnt_d;
            rel_cnt_q     <= rel_cnt_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_pressed_q <= key_pressed_d;
            key_col_q     <= key_col_d;
        end
    end

    assign kp.key_col     = key_col_q;
    assign kp.key_code    = key_code_q;
    assign kp.key_valid   = key_valid_q;
    assign kp.key_pressed = key_pressed_q;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed bench for keypad_matrix_scanner with a
// key-matrix model and a code scoreboard (SCAN_DIV = 4, DEBOUNCE_SCANS = 3).
module tb_keypad_matrix_scanner;
    logic clk;
    logic reset;
    logic [15:0] keys;          // keys[r*4+c] = 1 means key (row r, col c) pressed
    logic [3:0]  row_model;
    logic [3:0]  exp_q[$];
    int tests = 0;
    int fails = 0;
    int valid_seen = 0;

    keypad_matrix_scanner_if kp_if ();

    keypad_matrix_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed key shorts its row to the driven (low) column.
    always_comb begin
        row_model = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !kp_if.key_col[c]) row_model[r] = 1'b0;
            end
        end
    end
    assign kp_if.key_row = row_model;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected code.
    always @(negedge clk) begin
        if (reset === 1'b1 && kp_if.key_valid === 1'b1) begin
            valid_seen++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: got code %0h, required no strobe", kp_if.key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (kp_if.key_code !== e) begin
                    fails++;
                    $display("FAIL scoreboard_code: got %0h, required %0h", kp_if.key_code, e);
                end
            end
        end
    end

    // Wait for the column to newly become c; returns at the first negedge after the change.
    task automatic wait_col_edge(input logic [3:0] c);
        int n = 0;
        while (kp_if.key_col === c && n < 100) begin @(negedge clk); n++; end
        while (kp_if.key_col !== c && n < 100) begin @(negedge clk); n++; end
        check("wait_col_edge", kp_if.key_col, c);
    endtask

    task automatic wait_pressed(input string name, input logic v, input int budget);
        int n = 0;
        while (kp_if.key_pressed !== v && n < budget) begin @(negedge clk); n++; end
        check(name, kp_if.key_pressed, v);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] prev;
        int since, nchg, v0, n;

        reset = 1'b0;
        keys  = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_key_col", kp_if.key_col, 4'b1110);
        check("rst_key_code", kp_if.key_code, 4'h0);
        check("rst_key_valid", kp_if.key_valid, 1'b0);
        check("rst_key_pressed", kp_if.key_pressed, 1'b0);
        reset = 1'b1;

        // Idle: column rotates every 4 clocks, no strobes.
        prev = kp_if.key_col; since = 0; nchg = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            since++;
            if (kp_if.key_col !== prev) begin
                check("idle_col_step", kp_if.key_col, {prev[2:0], prev[3]});
                if (nchg > 0) check("idle_col_period", since, 4);
                nchg++;
                since = 0;
                prev = kp_if.key_col;
            end
        end
        check("idle_changes", (nchg >= 8) ? 1 : 0, 1);

        // Key 9 (row 2, col 1): exact press and release latency.
        wait_col_edge(4'b1101);
        keys[9] = 1'b1;
        exp_q.push_back(4'h9);
        repeat (11) @(negedge clk);
        check("press9_before_accept", kp_if.key_pressed, 1'b0);
        @(negedge clk);
        check("press9_pressed", kp_if.key_pressed, 1'b1);
        check("press9_valid", kp_if.key_valid, 1'b1);
        check("press9_code", kp_if.key_code, 4'h9);
        keys[9] = 1'b0;
        repeat (11) @(negedge clk);
        check("release9_still_held", kp_if.key_pressed, 1'b1);
        check("release9_col_held", kp_if.key_col, 4'b1101);
        @(negedge clk);
        check("release9_done", kp_if.key_pressed, 1'b0);
        check("release9_resume_col", kp_if.key_col, 4'b1011);
        check("release9_code_kept", kp_if.key_code, 4'h9);

        // Bounce on column 3: one low tick then high, no strobe, wraps to column 0.
        wait_col_edge(4'b0111);
        keys[3] = 1'b1;
        repeat (4) @(negedge clk);
        keys[3] = 1'b0;
        repeat (3) @(negedge clk);
        check("bounce_col_held", kp_if.key_col, 4'b0111);
        @(negedge clk);
        check("bounce_col_wrap", kp_if.key_col, 4'b1110);
        check("bounce_not_pressed", kp_if.key_pressed, 1'b0);

        // Rows 1 and 3 on column 0: row 1 wins.
        keys[4] = 1'b1;
        keys[12] = 1'b1;
        exp_q.push_back(4'h4);
        wait_pressed("multi_pressed", 1'b1, 200);
        check("multi_code", kp_if.key_code, 4'h4);
        keys[4] = 1'b0;
        keys[12] = 1'b0;
        wait_pressed("multi_released", 1'b0, 200);

        // Reset during DEBOUNCE with cnt = 2: immediate reset values, no strobe.
        wait_col_edge(4'b1101);
        keys[9] = 1'b1;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_key_col", kp_if.key_col, 4'b1110);
        check("midrst_key_code", kp_if.key_code, 4'h0);
        check("midrst_key_valid", kp_if.key_valid, 1'b0);
        check("midrst_key_pressed", kp_if.key_pressed, 1'b0);
        keys[9] = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        v0 = valid_seen;
        repeat (40) @(negedge clk);
        check("midrst_no_strobe", valid_seen, v0);

        // No rollover: key 0 pressed while 9 is held is reported only after release.
        keys[9] = 1'b1;
        exp_q.push_back(4'h9);
        wait_pressed("roll_press9", 1'b1, 200);
        @(negedge clk);
        keys[0] = 1'b1;
        v0 = valid_seen;
        repeat (60) @(negedge clk);
        check("roll_no_second_strobe", valid_seen, v0);
        check("roll_still_held", kp_if.key_pressed, 1'b1);
        check("roll_code_kept", kp_if.key_code, 4'h9);
        keys[9] = 1'b0;
        wait_pressed("roll_release9", 1'b0, 200);
        exp_q.push_back(4'h0);
        n = 0;
        while (valid_seen == v0 && n < 200) begin @(negedge clk); n++; end
        check("roll_second_strobe", valid_seen, v0 + 1);
        check("roll_code0", kp_if.key_code, 4'h0);
        keys[0] = 1'b0;
        wait_pressed("roll_release0", 1'b0, 200);

        repeat (20) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

Scans a 4x4 push-button matrix by driving one column low at a time and reading the four row lines back. It debounces the first key found and reports it as a 4-bit code with a one-cycle valid strobe and a held-level flag. It is the input-side counterpart of the LED dot-matrix row/column scanner and sits between the board keypad pins and the lab control logic.

## Interface
- SCAN_DIV, 2500: clk cycles per scan tick; legal range 4 or more.
- DEBOUNCE_SCANS, 8: consecutive agreeing ticks needed to accept a press or a release; legal range 1 or more.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- key_row  in  4  row sense lines, active-low, externally pulled up; asynchronous to clk.
- key_col  out  4  column drive, active-low one-hot.
- key_code  out  4  last accepted key, {row_idx[1:0], col_idx[1:0]}.
- key_valid  out  1  one-cycle strobe when a press is accepted.
- key_pressed  out  1  high from acceptance until the release is debounced.

## Operation
- Reset values:
  - key_col = 4'b1110 (column 0), key_code = 0, key_valid = 0, key_pressed = 0.
  - Synchronizer flops = 4'hF, prescaler = 0, counters = 0, state = SCAN.
- key_row passes through a 2-flop synchronizer; `rs` denotes the synchronized value.
- The prescaler counts 0..SCAN_DIV-1 and asserts `tick` for one cycle at SCAN_DIV-1, then wraps to 0. All FSM updates happen only on tick cycles.
- key_col = ~(4'b1 << col_idx). col_idx wraps 3 to 0.
- SCAN state:
  - If rs == 4'hF, increment col_idx.
  - Otherwise:
    - Capture cand_row = index of the lowest-numbered low bit of rs (row priority 0 > 1 > 2 > 3).
    - Capture cand_col = col_idx; col_idx is held.
    - Set cnt = 1.
    - If DEBOUNCE_SCANS == 1, accept immediately; else go to DEBOUNCE.
- DEBOUNCE state (column held):
  - If rs[cand_row] == 0, increment cnt.
  - When cnt reaches DEBOUNCE_SCANS, accept and go to HELD.
  - If rs[cand_row] == 1, clear cnt, increment col_idx, and return to SCAN.
- Accept:
  - key_code = {cand_row, cand_col}.
  - key_pressed = 1.
  - key_valid = 1 for exactly one clk cycle.
- HELD state (column held):
  - If rs[cand_row] == 1, increment rel_cnt; otherwise clear rel_cnt.
  - When rel_cnt reaches DEBOUNCE_SCANS:
    - key_pressed = 0, rel_cnt = 0.
    - Increment col_idx and go to SCAN.
    - key_code keeps its value.
- Keys pressed in other rows of the held column while in DEBOUNCE or HELD are ignored. There is no rollover: a second key is reported only after the first is released.
- Counters saturate at DEBOUNCE_SCANS and never wrap.
- Reset asserted mid-operation returns every register to its reset value asynchronously. No strobe is emitted for a press that was in progress.

## Timing
- Column-to-sample settling: each column is driven for a full SCAN_DIV cycles before it is sampled. The synchronizer adds 2 cycles, which fits because SCAN_DIV ≥ 4.
- Press latency: key_valid rises in the clk cycle after the edge of the DEBOUNCE_SCANS-th agreeing tick.
  - Counted from the first detecting tick, that is (DEBOUNCE_SCANS-1)·SCAN_DIV + 1 cycles.
  - Add 2 cycles of synchronizer delay from the pin.
- key_code, key_pressed and key_valid change on the same edge.
- Release latency: DEBOUNCE_SCANS ticks after the first high sample in HELD. key_valid stays 0 on release.

## Structure
- keypad_pkg holds:
  - The state enum {SCAN, DEBOUNCE, HELD}.
  - ROWS = 4, COLS = 4, and CODE_W = 4.
- Sub-module keypad_scan_tick holds the SCAN_DIV prescaler: inputs clk and reset, output tick. All other logic stays in keypad_matrix_scanner.

## Test plan
All scenarios use SCAN_DIV = 4 and DEBOUNCE_SCANS = 3.
- Idle, key_row = 4'hF: key_col cycles 1110→1101→1011→0111→1110, one step every 4 clk cycles; key_valid never asserts.
- Hold row 2 low only while key_col == 4'b1101, for 3 or more ticks: exactly one key_valid pulse with key_code = 4'h9. key_pressed stays high until 3 high ticks after release, then scanning resumes.
- Bounce: row 0 low for 1 tick, high for 1 tick, on column 3: no key_valid, and col_idx advances to 0.
- Rows 1 and 3 low together on column 0: key_code = 4'h4, row 1 wins.
- While key 4'h9 is held, press key 4'h0: no second strobe. After 9 is released, the next key_valid reports 4'h0.
- Assert reset during DEBOUNCE at cnt = 2: outputs return to their reset values immediately, and no key_valid is emitted.
